// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown feeding the seven-segment display, with a one-cycle done pulse on expiry.
// Latency: a load appears on the outputs one cycle after the start edge. All outputs are registered.
// No backpressure. start/cancel are sampled every cycle. The optional pause input exists only when COUNTDOWN_PAUSE_EN is defined.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
`ifdef COUNTDOWN_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [7:0] load_value,
  output logic [8:0] seconds,
  output logic       busy,
  output logic       done
);

  // Prescaler width. The wrap value TICKS_PER_SEC-1 always fits in $clog2(TICKS_PER_SEC) bits.
  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       value_q, value_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [8:0]       seconds_d;
  logic             busy_d;
  logic             done_d;
  logic             pause_i;
  logic [7:0]       load_clamped;
  logic             tick;

`ifdef COUNTDOWN_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // Clamp each BCD digit to 9 so a malformed menu value still counts sensibly.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {tens, ones};
  endfunction

  // BCD decrement. The caller never passes 00, because 01 expires first,
  // so the tens digit cannot borrow below zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones != 4'd0) begin
      ones = ones - 4'd1;
    end else begin
      ones = 4'd9;
      tens = tens - 4'd1;
    end
    return {tens, ones};
  endfunction

  assign load_clamped = clamp_bcd(load_value);

  // One-second tick: the prescaler wrap cycle while running and not frozen by pause.
  always_comb begin
    tick = 1'b0;
    if (state_q == ST_RUN && !pause_i && pre_q == PRE_LAST) begin
      tick = 1'b1;
    end
  end

  // Next-state logic. Priority is cancel, then load, then normal counting.
  // Output values are derived from the next state so they can be registered.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    pre_d   = pre_q;

    if (cancel) begin
      // Abort from any state. This also swallows a DONE that would have fired this edge.
      state_d = ST_IDLE;
      value_d = 8'h00;
      pre_d   = '0;
    end else if (start) begin
      // A load restarts from the top of a second, even when already running.
      pre_d = '0;
      if (load_clamped == 8'h00) begin
        state_d = ST_DONE;
        value_d = 8'h00;
      end else begin
        state_d = ST_RUN;
        value_d = load_clamped;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (!pause_i) begin
            if (tick) begin
              pre_d = '0;
              if (value_q == 8'h01) begin
                // Expire on the 01 -> 00 step. 00 is never shown while running.
                state_d = ST_DONE;
                value_d = 8'h00;
              end else begin
                value_d = bcd_dec(value_q);
              end
            end else begin
              pre_d = pre_q + PRE_ONE;
            end
          end
        end
        ST_DONE: begin
          // DONE lasts exactly one cycle.
          state_d = ST_IDLE;
          value_d = 8'h00;
          pre_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          value_d = 8'h00;
          pre_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state. The display is only enabled while counting.
  always_comb begin
    seconds_d = 9'h000;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (state_d == ST_RUN) begin
      seconds_d = {1'b1, value_d};
      busy_d    = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  // State, count and registered outputs. Asynchronous reset clears everything at once.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      value_q <= 8'h00;
      pre_q   <= '0;
      seconds <= 9'h000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      pre_q   <= pre_d;
      seconds <= seconds_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICKS_PER_SEC=4.
// Expected output events are queued as (cycle, value) and checked by a separate monitor.
// Any output change with no matching expected event is reported.
module tb_countdown_timer;

  localparam int TPS = 4;

  logic       clk_out = 1'b0;
  logic       reset;
  logic       start;
  logic       cancel;
  logic       pause;
  logic [7:0] load_value;
  logic [8:0] seconds;
  logic       busy;
  logic       done;

  countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk_out    (clk_out),
    .reset      (reset),
    .start      (start),
    .cancel     (cancel),
`ifdef COUNTDOWN_PAUSE_EN
    .pause      (pause),
`endif
    .load_value (load_value),
    .seconds    (seconds),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_out = ~clk_out;

  // Edge counter. After rising edge k, the monitor sees cyc == k on the falling edge.
  int cyc = 0;
  always @(posedge clk_out) cyc <= cyc + 1;

  // Scoreboard queues: cycle stamp, {seconds, busy, done}, and a tag.
  int          exp_cyc[$];
  logic [10:0] exp_val[$];
  string       exp_tag[$];

  int   n_assert = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  task automatic expect_at(input int c, input logic [8:0] s, input logic b,
                           input logic d, input string tag);
    exp_cyc.push_back(c);
    exp_val.push_back({s, b, d});
    exp_tag.push_back(tag);
  endtask

  // Monitor: check a due event, flag missed events, and flag any unscheduled output change.
  logic [10:0] cur;
  logic [10:0] prev;
  always @(negedge clk_out) begin
    cur = {seconds, busy, done};
    if (mon_en) begin
      while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        n_assert++;
        n_fail++;
        $display("FAIL %s: event due at cycle %0d not checked (now %0d), required seconds=%h busy=%b done=%b",
                 exp_tag[0], exp_cyc[0], cyc, exp_val[0][10:2], exp_val[0][1], exp_val[0][0]);
        void'(exp_cyc.pop_front());
        void'(exp_val.pop_front());
        void'(exp_tag.pop_front());
      end
      if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
        n_assert++;
        if (cur !== exp_val[0]) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got seconds=%h busy=%b done=%b, required seconds=%h busy=%b done=%b",
                   exp_tag[0], cyc, cur[10:2], cur[1], cur[0],
                   exp_val[0][10:2], exp_val[0][1], exp_val[0][0]);
        end
        void'(exp_cyc.pop_front());
        void'(exp_val.pop_front());
        void'(exp_tag.pop_front());
      end else if (cur !== prev) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_change @cycle %0d: got seconds=%h busy=%b done=%b, required unchanged seconds=%h busy=%b done=%b",
                 cyc, cur[10:2], cur[1], cur[0], prev[10:2], prev[1], prev[0]);
      end
    end
    prev = cur;
  end

  // Call at a falling edge. Inputs take effect at the next rising edge, whose number is returned.
  task automatic drive(input logic st, input logic cn, input logic [7:0] v, output int edge_n);
    start      = st;
    cancel     = cn;
    load_value = v;
    edge_n     = cyc + 1;
  endtask

  task automatic release_inputs();
    @(negedge clk_out);
    start  = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_out);
  endtask

  logic [7:0] seq12 [12] = '{8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07,
                             8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

  initial begin
    int l;
    int e;
    int t0;
    reset      = 1'b1;
    start      = 1'b0;
    cancel     = 1'b0;
    pause      = 1'b0;
    load_value = 8'h00;
    repeat (3) @(negedge clk_out);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state held through 10 idle cycles.
    t0 = cyc;
    for (int i = 1; i <= 10; i++) expect_at(t0 + i, 9'h000, 1'b0, 1'b0, "reset_idle");
    wait_until(t0 + 11);

    // 12 counts down through the BCD borrow. done comes 48 cycles after the load.
    drive(1'b1, 1'b0, 8'h12, l);
    for (int i = 0; i < 12; i++) expect_at(l + 4 * i, {1'b1, seq12[i]}, 1'b1, 1'b0, "count12");
    expect_at(l + 48, 9'h000, 1'b0, 1'b1, "done12");
    expect_at(l + 49, 9'h000, 1'b0, 1'b0, "idle_after12");
    release_inputs();
    wait_until(l + 54);

    // Load 00: immediate single-cycle done, never busy.
    drive(1'b1, 1'b0, 8'h00, l);
    expect_at(l,     9'h000, 1'b0, 1'b1, "done00");
    expect_at(l + 1, 9'h000, 1'b0, 1'b0, "idle_after00");
    release_inputs();
    wait_until(l + 6);

    // Digit clamping, each followed by a cancel back to idle.
    drive(1'b1, 1'b0, 8'hA3, l);
    expect_at(l, 9'h193, 1'b1, 1'b0, "clamp_A3");
    release_inputs();
    drive(1'b0, 1'b1, 8'h00, e);
    expect_at(e, 9'h000, 1'b0, 1'b0, "cancel_A3");
    release_inputs();
    wait_until(e + 3);
    drive(1'b1, 1'b0, 8'h3F, l);
    expect_at(l, 9'h139, 1'b1, 1'b0, "clamp_3F");
    release_inputs();
    drive(1'b0, 1'b1, 8'h00, e);
    expect_at(e, 9'h000, 1'b0, 1'b0, "cancel_3F");
    release_inputs();
    wait_until(e + 3);

    // A cancel on the expiry edge suppresses done.
    drive(1'b1, 1'b0, 8'h01, l);
    expect_at(l, 9'h101, 1'b1, 1'b0, "load01");
    release_inputs();
    wait_until(l + 3);
    drive(1'b0, 1'b1, 8'h00, e);
    expect_at(e, 9'h000, 1'b0, 1'b0, "cancel_on_expiry");
    release_inputs();
    wait_until(l + 12);

    // Restart mid-run with 20, then start+cancel together: cancel wins, no done.
    drive(1'b1, 1'b0, 8'h05, l);
    expect_at(l,     9'h105, 1'b1, 1'b0, "load05");
    expect_at(l + 4, 9'h104, 1'b1, 1'b0, "tick05");
    release_inputs();
    wait_until(l + 5);
    drive(1'b1, 1'b0, 8'h20, e);
    expect_at(l + 6,  9'h120, 1'b1, 1'b0, "restart20");
    expect_at(l + 10, 9'h119, 1'b1, 1'b0, "prescaler_restart");
    release_inputs();
    wait_until(l + 11);
    drive(1'b1, 1'b1, 8'h20, e);
    expect_at(l + 12, 9'h000, 1'b0, 1'b0, "cancel_wins");
    release_inputs();
    wait_until(l + 35);

    // Reset asserted between edges at cycle 7 of a 05 run clears the outputs at once.
    drive(1'b1, 1'b0, 8'h05, l);
    expect_at(l,     9'h105, 1'b1, 1'b0, "load05b");
    expect_at(l + 4, 9'h104, 1'b1, 1'b0, "tick05b");
    expect_at(l + 7, 9'h000, 1'b0, 1'b0, "async_reset");
    release_inputs();
    wait_until(l + 6);
    @(posedge clk_out);
    #1 reset = 1'b1;
    @(negedge clk_out);
    @(negedge clk_out);
    reset = 1'b0;
    wait_until(l + 40);

`ifdef COUNTDOWN_PAUSE_EN
    // Pause for 20 edges mid-second delays every later event by 20 cycles.
    drive(1'b1, 1'b0, 8'h03, l);
    expect_at(l,      9'h103, 1'b1, 1'b0, "load03");
    expect_at(l + 24, 9'h102, 1'b1, 1'b0, "paused_tick1");
    expect_at(l + 28, 9'h101, 1'b1, 1'b0, "paused_tick2");
    expect_at(l + 32, 9'h000, 1'b0, 1'b1, "paused_done");
    expect_at(l + 33, 9'h000, 1'b0, 1'b0, "paused_idle");
    release_inputs();
    wait_until(l + 1);
    pause = 1'b1;
    wait_until(l + 21);
    pause = 1'b0;
    wait_until(l + 40);
`endif

    repeat (5) @(negedge clk_out);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog bounds the run if the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d assertions, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD seconds countdown timer that drives the `seconds` bus of the seven-segment display stage. The menu controller loads a two-digit BCD value and starts it. The block then decrements it once per second and reports expiry with a single-cycle `done` pulse. Bit 8 of `seconds` is the display-enable flag: it is 1 only while a countdown is running.

## Interface
- `TICKS_PER_SEC`, default 100000000: `clk_out` cycles per second; legal range ≥ 2.
- `clk_out`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset, asynchronous, active-high.
- `start`  input  1  level sampled each cycle; high loads `load_value` and starts or restarts the countdown.
- `cancel`  input  1  abort the countdown; has priority over `start`.
- `load_value`  input  8  BCD start value: [7:4] tens, [3:0] ones.
- `seconds`  output  9  {active, tens, ones}; connects straight to the display's `seconds` input.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse on expiry.

## Operation
- States:
  - IDLE: `seconds=9'h000`, `busy=0`.
  - RUN: counting; `seconds[8]=1`.
  - DONE: one cycle; `done=1`, `seconds=9'h000`, `busy=0`.
- Prescaler `pre`, width `$clog2(TICKS_PER_SEC)`:
  - Counts 0..TICKS_PER_SEC-1 in RUN, then wraps.
  - Wrap cycle = tick.
  - Cleared on every load.
- Load (`start=1`, `cancel=0`, any state):
  - Each BCD digit >9 is clamped to 9.
  - Clamped value ≠ 00: value ← clamped value, `pre` ← 0, go to RUN. A load in RUN restarts the count.
  - Clamped value = 00: go to DONE directly; RUN is never entered.
- Tick in RUN, BCD decrement:
  - ones ≠ 0: ones−1.
  - ones = 0: ones←9, tens−1.
  - Result 00: go to DONE instead of showing 00.
- `cancel=1`:
  - From RUN or DONE: go to IDLE, value and `pre` cleared.
  - No `done` pulse is emitted; a pending DONE is suppressed.
  - `cancel` and `start` high together: cancel wins.
- DONE goes to IDLE unconditionally on the next cycle, unless `start` reloads.
- Tens digit never underflows: the 00 detection precedes any borrow from tens=0.

## Timing
- Reset values: `seconds=9'h000`, `busy=0`, `done=0`, state IDLE, `pre=0`, value 00.
- All outputs are registered; none are combinational from inputs.
- Load latency is 1 cycle: `start` high at edge k gives `seconds={1,value}` and `busy=1` after edge k.
- Value N loaded at edge k:
  - `seconds` shows N for TICKS_PER_SEC cycles, then N−1, and so on down to 01.
  - `done` is high for exactly one cycle, beginning at edge k + N·TICKS_PER_SEC.
  - `busy` falls at that same edge.
- Load value 00 at edge k: `done` is high after edge k for one cycle.
- `reset` asserted mid-count: all outputs return to reset values immediately (asynchronous). No `done`.

## Configuration
- `COUNTDOWN_PAUSE_EN` defined:
  - Adds input `pause` (1 bit).
  - In RUN with `pause=1`: `pre` and value are frozen; `busy=1` and `seconds[8]=1` hold.
  - `cancel`, `start` and `reset` still act while paused.
  - `pause` has no effect in IDLE or DONE.
- `COUNTDOWN_PAUSE_EN` not defined: the port is absent and the block behaves as if `pause=0`.

## Test plan
All scenarios use `TICKS_PER_SEC=4`.
- Reset, then idle 10 cycles → `seconds=000`, `busy=0`, `done=0` throughout. Assert `reset` at cycle 7 of a run of value 05 → outputs go to 0 immediately, and no `done` ever appears.
- `load_value=8'h12`, pulse `start` → `seconds`: 112 (4 cycles), 111 (4), 110 (4), 109 (BCD borrow), …, 101. `done` is a single pulse exactly 48 cycles after the load edge; `seconds=000` on that cycle.
- `load_value=8'h00`, pulse `start` → `done` high for one cycle on the next cycle; `busy` never rises; `seconds` stays 000.
- `load_value=8'hA3` → `seconds=193`. `load_value=8'h3F` → `seconds=139`.
- Value 05 running: at cycle 6, `start` with 8'h20 → `seconds=120` and `pre` restarts, so the next change is 4 cycles later. Then `start` and `cancel` together → IDLE, `seconds=000`, no `done`.
- With `COUNTDOWN_PAUSE_EN`: load 03, hold `pause` 20 cycles mid-second → `seconds` frozen at 103; after release, the remaining ticks resume, and `done` comes 20 cycles later than in the unpaused run.
